// File: rtl/scoreboard_regfile_pkg.sv
// scoreboard_regfile_pkg: shared register file and scoreboard constants
`include "regfile_defs.vh"
package scoreboard_regfile_pkg;
  localparam int RF_DATA_W = `RF_DATA_W;
  localparam int RF_NREGS = `RF_NREGS;
  localparam int RF_ADDR_W = `RF_ADDR_W;
  localparam int RF_NUM_RD = 2;
  localparam int RF_PEND_W = `RF_PEND_W;
  localparam int RF_PEND_MAX = `PEND_MAX;
endpackage

// File: rtl/regfile_defs.vh
`ifndef REGFILE_DEFS_VH
`define REGFILE_DEFS_VH
`define RF_DATA_W 16
`define RF_NREGS 16
`define RF_ADDR_W 4
`define RF_PEND_W 2
`define PEND_MAX ((1 << `RF_PEND_W) - 1)
`endif

// File: rtl/scoreboard_regfile_sb_counter.sv
// sb_counter: saturating pending-write counter for one register (WB_BYPASS_EN adds last)
import scoreboard_regfile_pkg::*;
module sb_counter #(
  parameter int PEND_W = RF_PEND_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
`ifdef WB_BYPASS_EN
  output logic last,
`endif
  output logic busy,
  output logic full,
  output logic underflow
);
  logic [PEND_W-1:0] cnt_q, cnt_d;
  always_comb begin
    busy = |cnt_q;
    full = &cnt_q;
    underflow = dec && !busy;
    cnt_d = (inc && !dec && !full) ? cnt_q + PEND_W'(1) :
            (dec && !inc && busy) ? cnt_q - PEND_W'(1) : cnt_q;
  end
`ifdef WB_BYPASS_EN
  assign last = cnt_q <= PEND_W'(1);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: multi-port register file with counted pending-write scoreboard
// WB_BYPASS_EN forwards same-cycle writeback data and busy release to the read ports.
import scoreboard_regfile_pkg::*;
module scoreboard_regfile #(
  parameter int DATA_W = RF_DATA_W,
  parameter int NREGS = RF_NREGS,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD,
  parameter int PEND_W = RF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     alloc_valid,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_ready,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wb_done,
  output logic                     sb_err
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0] inc, dec, busy, full, uflow;
  logic wb_done_q, wb_done_d, sb_err_q, sb_err_d;
`ifdef WB_BYPASS_EN
  logic [NREGS-1:0] last;
`endif
  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_cnt
      sb_counter #(.PEND_W(PEND_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(inc[i]),
        .dec(dec[i]),
`ifdef WB_BYPASS_EN
        .last(last[i]),
`endif
        .busy(busy[i]),
        .full(full[i]),
        .underflow(uflow[i])
      );
    end
  endgenerate
  always_comb begin
    alloc_ready = !full[alloc_addr];
    inc = '0;
    dec = '0;
    inc[alloc_addr] = alloc_valid && alloc_ready;
    dec[wb_addr] = wb_valid;
    regs_d = regs_q;
    if (wb_valid) regs_d[wb_addr] = wb_data;
    wb_done_d = wb_valid;
    sb_err_d = sb_err_q || (|uflow);
  end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] ra;
      ra = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef WB_BYPASS_EN
      rd_data[p*DATA_W +: DATA_W] = (wb_valid && wb_addr == ra) ? wb_data : regs_q[ra];
      rd_busy[p] = (wb_valid && wb_addr == ra) ? !last[ra] : busy[ra];
`else
      rd_data[p*DATA_W +: DATA_W] = regs_q[ra];
      rd_busy[p] = busy[ra];
`endif
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      wb_done_q <= 1'b0;
      sb_err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wb_done_q <= wb_done_d;
      sb_err_q <= sb_err_d;
    end
  assign wb_done = wb_done_q;
  assign sb_err = sb_err_q;
endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb_scoreboard_regfile: directed checks of scoreboard_regfile with default parameters
module tb_scoreboard_regfile;
  logic clk, rst;
  logic [7:0] rd_addr;
  logic [31:0] rd_data;
  logic [1:0] rd_busy;
  logic alloc_valid, alloc_ready, wb_valid, wb_done, sb_err;
  logic [3:0] alloc_addr, wb_addr;
  logic [15:0] wb_data;
  int checks, failures;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  scoreboard_regfile dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_done(wb_done), .sb_err(sb_err)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    rd_addr = 8'h33;
    alloc_valid = 0; alloc_addr = 4'd3;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    #12;
    check("rst_busy", rd_busy, 2'b00);
    check("rst_ready", alloc_ready, 1);
    check("rst_done", wb_done, 0);
    rst = 1'b0;
    step();
    // test 1: reset mid-run
    alloc_valid = 1; alloc_addr = 4'd3;
    step(); step();
    alloc_valid = 0;
    wb_valid = 1; wb_addr = 4'd3; wb_data = 16'h0055;
    step();
    wb_valid = 0; #1;
    check("t1_busy_pre", rd_busy, 2'b11);
    check("t1_data_pre", rd_data, 32'h00550055);
    pulse_rst();
    check("t1_busy", rd_busy, 2'b00);
    check("t1_data", rd_data, 32'h0);
    check("t1_err", sb_err, 0);
    check("t1_ready", alloc_ready, 1);
    check("t1_done", wb_done, 0);
    // test 2: alloc then writeback r3
    alloc_valid = 1; alloc_addr = 4'd3;
    step();
    alloc_valid = 0; #1;
    check("t2_busy", rd_busy[0], 1);
    wb_valid = 1; wb_addr = 4'd3; wb_data = 16'h0100; #1;
    check("t2_busy_wb", rd_busy[0], !BYP);
    check("t2_data_wb", rd_data[15:0], BYP ? 16'h0100 : 16'h0000);
    step();
    wb_valid = 0; #1;
    check("t2_done", wb_done, 1);
    check("t2_busy_after", rd_busy[0], 0);
    check("t2_data", rd_data[15:0], 16'h0100);
    step();
    check("t2_done_off", wb_done, 0);
    // test 3: saturate r5, ignored 4th alloc, saturated alloc+wb
    rd_addr = 8'h55;
    alloc_valid = 1; alloc_addr = 4'd5;
    for (int k = 0; k < 3; k++) begin
      #1 check("t3_ready", alloc_ready, 1);
      step();
    end
    check("t3_full", alloc_ready, 0);
    step();
    check("t3_still_full", alloc_ready, 0);
    wb_valid = 1; wb_addr = 4'd5; wb_data = 16'h0005;
    step();
    alloc_valid = 0;
    check("t3_done1", wb_done, 1);
    check("t3_busy1", rd_busy, 2'b11);
    check("t3_ready_after", alloc_ready, 1);
    step();
    check("t3_done2", wb_done, 1);
    check("t3_busy2", rd_busy, 2'b11);
    step();
    wb_valid = 0; #1;
    check("t3_done3", wb_done, 1);
    check("t3_busy3", rd_busy, 2'b00);
    check("t3_err", sb_err, 0);
    // test 4: same-cycle alloc+wb r7 with count 1
    rd_addr = 8'h77;
    alloc_valid = 1; alloc_addr = 4'd7;
    step();
    wb_valid = 1; wb_addr = 4'd7; wb_data = 16'hA5A5;
    step();
    alloc_valid = 0; wb_valid = 0; #1;
    check("t4_busy", rd_busy, 2'b11);
    check("t4_data", rd_data, 32'hA5A5A5A5);
    wb_valid = 1; wb_data = 16'h5A5A;
    step();
    wb_valid = 0; #1;
    check("t4_busy_clr", rd_busy, 2'b00);
    check("t4_err", sb_err, 0);
    // test 5: writeback with count 0
    rd_addr = 8'h99;
    wb_valid = 1; wb_addr = 4'd9; wb_data = 16'hBEEF;
    step();
    wb_valid = 0; #1;
    check("t5_data", rd_data, 32'hBEEFBEEF);
    check("t5_err", sb_err, 1);
    check("t5_busy", rd_busy, 2'b00);
    step(); step();
    check("t5_err_sticky", sb_err, 1);
    // test 6: same-cycle read of r2 during writeback
    wb_valid = 1; wb_addr = 4'd2; wb_data = 16'h1111;
    step();
    wb_valid = 0;
    rd_addr = 8'h22; #1;
    check("t6_old", rd_data, 32'h11111111);
    wb_valid = 1; wb_data = 16'h1234; #1;
    check("t6_same", rd_data, BYP ? 32'h12341234 : 32'h11111111);
    step();
    wb_valid = 0; #1;
    check("t6_next", rd_data, 32'h12341234);
    pulse_rst();
    check("end_err", sb_err, 0);
    check("end_data", rd_data, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
